// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the symbol-to-byte packet receive controller.
package rx_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  localparam int SYMS_PER_BYTE  = 4;
  localparam int SYM_CNT_W      = $clog2(SYMS_PER_BYTE);
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_TO_W       = 16;

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through FIFO for {last, byte} entries with full/empty flags.
module rx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = i_push && (!o_full || do_pop);
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rx_pkt_ctrl.sv
// Packs 2-bit hard-decision symbols MSB-first into bytes after a start-of-packet
// pulse and streams them out through a byte FIFO with a valid/ready handshake.
module rx_pkt_ctrl
  import rx_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int TO_W       = DEF_TO_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [LEN_W-1:0] i_pkt_len,
  input  logic [TO_W-1:0]  i_timeout,
  input  logic             i_sop,
  input  logic [1:0]       i_sym,
  input  logic             i_sym_vld,
  input  logic             i_sym_err,
  output logic [7:0]       o_byte,
  output logic             o_last,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic             o_busy,
  output logic             o_pkt_done,
  output logic             o_pkt_abort,
  output logic             o_ovf,
  output logic [7:0]       o_err_cnt
);

  localparam int SHIFT_W = 2 * (SYMS_PER_BYTE - 1);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [TO_W-1:0]      idle_q, idle_d;
  logic                 push_q, push_d;
  logic [8:0]           push_data_q, push_data_d;
  logic                 done_q, done_d, abort_q, abort_d, ovf_q, ovf_d;
  logic [7:0]           err_q, err_d;
  logic                 last_byte;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [8:0]           fifo_rdata;

  assign o_vld       = !fifo_empty;
  assign fifo_pop    = o_vld && i_rdy;
  assign o_byte      = o_vld ? fifo_rdata[7:0] : 8'h00;
  assign o_last      = o_vld && fifo_rdata[8];
  assign o_busy      = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
  assign o_pkt_done  = done_q;
  assign o_pkt_abort = abort_q;
  assign o_ovf       = ovf_q;
  assign o_err_cnt   = err_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    shift_d     = shift_q;
    idle_d      = idle_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    ovf_d       = ovf_q | (push_q & fifo_full & ~fifo_pop);
    err_d       = err_q;
    last_byte   = 1'b0;
    case (state_q)
      ST_IDLE: if (i_en) state_d = ST_SEARCH;
      ST_SEARCH: begin
        // The symbol sharing the SOP cycle belongs to the preamble, not the payload.
        if (i_sop) begin
          state_d    = ST_CAPTURE;
          len_d      = (i_pkt_len == '0) ? LEN_W'(1) : i_pkt_len;
          byte_cnt_d = '0;
          sym_cnt_d  = '0;
          shift_d    = '0;
          idle_d     = '0;
        end
      end
      ST_CAPTURE: begin
        if (i_sym_vld) begin
          idle_d    = '0;
          shift_d   = {shift_q[SHIFT_W-3:0], i_sym};
          sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
          if (i_sym_err && err_q != 8'hFF) err_d = err_q + 8'd1;
          if (sym_cnt_q == SYM_CNT_W'(SYMS_PER_BYTE - 1)) begin
            sym_cnt_d   = '0;
            byte_cnt_d  = byte_cnt_q + LEN_W'(1);
            last_byte   = (byte_cnt_d == len_q);
            push_d      = 1'b1;
            push_data_d = {last_byte, shift_q, i_sym};
            if (last_byte) begin
              done_d  = 1'b1;
              state_d = ST_FLUSH;
            end
          end
        end else if (i_timeout != '0 && idle_q == i_timeout) begin
          abort_d   = 1'b1;
          state_d   = ST_SEARCH;
          sym_cnt_d = '0;
          shift_d   = '0;
        end else if (idle_q != '1) begin
          idle_d = idle_q + TO_W'(1);
        end
      end
      ST_FLUSH: if (fifo_empty && !push_q) state_d = ST_SEARCH;
      default: state_d = ST_IDLE;
    endcase
    if (!i_en) begin
      state_d   = ST_IDLE;
      push_d    = 1'b0;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      ovf_d     = 1'b0;
      err_d     = '0;
      sym_cnt_d = '0;
      shift_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      sym_cnt_q   <= '0;
      shift_q     <= '0;
      idle_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      shift_q     <= shift_d;
      idle_q      <= idle_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (!i_en),
    .i_push  (push_q),
    .i_data  (push_data_q),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Self-checking bench for rx_pkt_ctrl: directed and randomized packets against a
// symbol-list packing model, plus timeout, overflow, error-count and reset scenarios.
module tb_rx_pkt_ctrl;

  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 8;
  localparam int TO_W       = 16;

  logic             i_clk = 1'b0;
  logic             i_rst, i_en, i_sop, i_sym_vld, i_sym_err, i_rdy;
  logic [LEN_W-1:0] i_pkt_len;
  logic [TO_W-1:0]  i_timeout;
  logic [1:0]       i_sym;
  logic [7:0]       o_byte, o_err_cnt;
  logic             o_last, o_vld, o_busy, o_pkt_done, o_pkt_abort, o_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int first_vld_cyc = -1;
  int abort_cyc = -1;
  logic [8:0] got_q[$];

  rx_pkt_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_pkt_len(i_pkt_len),
    .i_timeout(i_timeout), .i_sop(i_sop), .i_sym(i_sym), .i_sym_vld(i_sym_vld),
    .i_sym_err(i_sym_err), .o_byte(o_byte), .o_last(o_last), .o_vld(o_vld),
    .i_rdy(i_rdy), .o_busy(o_busy), .o_pkt_done(o_pkt_done),
    .o_pkt_abort(o_pkt_abort), .o_ovf(o_ovf), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Observes the current cycle (1 time unit after the edge), then advances one clock.
  task automatic tick();
    if (o_vld && i_rdy) got_q.push_back({o_last, o_byte});
    if (o_pkt_done) done_cnt++;
    if (o_pkt_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (o_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic sop, input logic vld, input logic [1:0] sym, input logic err);
    i_sop = sop; i_sym_vld = vld; i_sym = sym; i_sym_err = err;
    tick();
    i_sop = 1'b0; i_sym_vld = 1'b0; i_sym_err = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!o_vld && !o_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    checks++; if (o_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte got %h exp 00", o_byte); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b exp 0", o_vld); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b exp 0", o_last); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if ({o_pkt_done, o_pkt_abort, o_ovf} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", {o_pkt_done, o_pkt_abort, o_ovf}); end
    checks++; if (o_err_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_errcnt got %0d exp 0", o_err_cnt); end
  endtask

  task automatic test_directed();
    logic [1:0] seq [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    int d0, c4;
    bit ok;
    got_q.delete(); d0 = done_cnt; first_vld_cyc = -1;
    i_pkt_len = 8'd2; i_rdy = 1'b1;
    drive(1'b1, 1'b1, 2'd3, 1'b0);
    c4 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) c4 = cyc;
      drive(1'b0, 1'b1, seq[i], 1'b0);
    end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL directed_drain got busy exp idle"); end
    checks++; if (first_vld_cyc !== c4 + 2) begin errors++; $display("[TB] FAIL directed_latency got %0d exp %0d", first_vld_cyc - c4, 2); end
    checks++; if (got_q.size() !== 2) begin errors++; $display("[TB] FAIL directed_count got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 9'h0E4) begin errors++; $display("[TB] FAIL directed_byte0 got %h exp 0e4", got_q[0]); end
      checks++; if (got_q[1] !== 9'h11B) begin errors++; $display("[TB] FAIL directed_byte1 got %h exp 11b", got_q[1]); end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL directed_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_random_packets();
    logic [1:0] syms[$];
    logic [8:0] exp_q[$];
    logic [1:0] v;
    int len, eff, d0, a0;
    bit ok;
    for (int p = 0; p < 8; p++) begin
      got_q.delete(); syms.delete(); exp_q.delete();
      d0 = done_cnt; a0 = abort_cnt;
      len = $urandom_range(0, 5);
      eff = (len == 0) ? 1 : len;
      i_pkt_len = LEN_W'(len); i_rdy = 1'b1;
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b1, 2'($urandom), 1'b0);
      drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom), 1'b0);
      for (int s = 0; s < 4 * eff; s++) begin
        v = 2'($urandom);
        repeat ($urandom_range(0, 2)) begin
          i_rdy = 1'($urandom_range(0, 1));
          drive(1'($urandom_range(0, 3) == 0), 1'b0, 2'd0, 1'b0);
        end
        i_rdy = ($urandom_range(0, 3) != 0);
        drive(1'($urandom_range(0, 3) == 0), 1'b1, v, 1'($urandom_range(0, 1)));
        syms.push_back(v);
      end
      i_rdy = 1'b1;
      wait_idle(200, ok);
      for (int b = 0; b < eff; b++)
        exp_q.push_back({1'(b == eff - 1), syms[4*b], syms[4*b+1], syms[4*b+2], syms[4*b+3]});
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_drain got busy exp idle", p); end
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rand%0d_count got %0d exp %0d", p, got_q.size(), exp_q.size()); end
      for (int b = 0; b < eff && b < got_q.size(); b++) begin
        checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("[TB] FAIL rand%0d_byte%0d got %h exp %h", p, b, got_q[b], exp_q[b]); end
      end
      checks++; if (done_cnt - d0 !== 1 || abort_cnt != a0) begin errors++; $display("[TB] FAIL rand%0d_pulses got done %0d abort %0d exp 1 0", p, done_cnt - d0, abort_cnt - a0); end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] s [5];
    int d0, a0, last_sym;
    bit ok;
    got_q.delete(); d0 = done_cnt; a0 = abort_cnt; abort_cyc = -1;
    i_timeout = 16'd10; i_pkt_len = 8'd4; i_rdy = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    last_sym = 0;
    for (int i = 0; i < 5; i++) begin
      s[i] = 2'($urandom);
      last_sym = cyc;
      drive(1'b0, 1'b1, s[i], 1'b0);
    end
    repeat (20) tick();
    wait_idle(50, ok);
    checks++; if (abort_cnt - a0 !== 1) begin errors++; $display("[TB] FAIL timeout_abort got %0d exp 1", abort_cnt - a0); end
    checks++; if (abort_cyc - last_sym < 11 || abort_cyc - last_sym > 12) begin errors++; $display("[TB] FAIL timeout_when got %0d exp 11..12", abort_cyc - last_sym); end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_state got busy exp search"); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("[TB] FAIL timeout_count got %0d exp 1", got_q.size()); end
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== {1'b0, s[0], s[1], s[2], s[3]}) begin errors++; $display("[TB] FAIL timeout_byte got %h exp %h", got_q[0], {1'b0, s[0], s[1], s[2], s[3]}); end
    end
    checks++; if (done_cnt != d0) begin errors++; $display("[TB] FAIL timeout_done got %0d exp 0", done_cnt - d0); end
    i_timeout = '0;
  endtask

  task automatic test_overflow();
    logic [1:0] syms[$];
    logic [7:0] exp_b [20];
    int d0;
    bit ok;
    got_q.delete(); d0 = done_cnt;
    i_pkt_len = 8'd20; i_rdy = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 80; i++) syms.push_back(2'($urandom));
    for (int b = 0; b < 20; b++) exp_b[b] = {syms[4*b], syms[4*b+1], syms[4*b+2], syms[4*b+3]};
    for (int i = 0; i < 80; i++) begin
      drive(1'b0, 1'b1, syms[i], 1'b0);
      if (o_vld && (o_byte !== exp_b[0] || o_last !== 1'b0)) begin
        checks++; errors++;
        $display("[TB] FAIL ovf_hold got %h/%b exp %h/0", o_byte, o_last, exp_b[0]);
      end
    end
    repeat (4) tick();
    checks++; if (o_byte !== exp_b[0]) begin errors++; $display("[TB] FAIL ovf_stall_byte got %h exp %h", o_byte, exp_b[0]); end
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b exp 1", o_ovf); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL ovf_done got %0d exp 1", done_cnt - d0); end
    i_rdy = 1'b1;
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_drain got busy exp idle"); end
    checks++; if (got_q.size() !== FIFO_DEPTH) begin errors++; $display("[TB] FAIL ovf_count got %0d exp %0d", got_q.size(), FIFO_DEPTH); end
    for (int b = 0; b < FIFO_DEPTH && b < got_q.size(); b++) begin
      checks++; if (got_q[b] !== {1'b0, exp_b[b]}) begin errors++; $display("[TB] FAIL ovf_byte%0d got %h exp %h", b, got_q[b], {1'b0, exp_b[b]}); end
    end
  endtask

  task automatic test_err_cnt_and_disable();
    i_en = 1'b0; tick();
    checks++; if (o_ovf !== 1'b0 || o_err_cnt !== 8'h00) begin errors++; $display("[TB] FAIL en_clear got ovf %b cnt %0d exp 0 0", o_ovf, o_err_cnt); end
    i_en = 1'b1; tick();
    i_pkt_len = 8'd255; i_rdy = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'($urandom), 1'b1);
    drive(1'b0, 1'b1, 2'($urandom), 1'b0);
    checks++; if (o_err_cnt !== 8'd3) begin errors++; $display("[TB] FAIL err_cnt3 got %0d exp 3", o_err_cnt); end
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 2'($urandom), 1'b1);
    checks++; if (o_err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL err_sat got %0d exp 255", o_err_cnt); end
    i_rdy = 1'b0;
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 2'($urandom), 1'b0);
    checks++; if (o_vld !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL dis_pre got vld %b busy %b exp 1 1", o_vld, o_busy); end
    i_en = 1'b0; tick();
    checks++; if (o_vld !== 1'b0) begin errors++; $display("[TB] FAIL dis_vld got %b exp 0", o_vld); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL dis_busy got %b exp 0", o_busy); end
    checks++; if (o_err_cnt !== 8'h00) begin errors++; $display("[TB] FAIL dis_errcnt got %0d exp 0", o_err_cnt); end
    i_en = 1'b1; i_rdy = 1'b1; tick();
  endtask

  task automatic test_reset_mid_capture();
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    i_pkt_len = 8'd4; i_rdy = 1'b0; i_timeout = 16'd3;
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 2'($urandom), 1'b1);
    checks++; if (o_vld !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre got vld %b busy %b exp 1 1", o_vld, o_busy); end
    i_rst = 1'b1; tick();
    checks++; if ({o_vld, o_last, o_busy, o_ovf, o_pkt_done, o_pkt_abort} !== 6'b0) begin errors++; $display("[TB] FAIL rst_flags got %b exp 000000", {o_vld, o_last, o_busy, o_ovf, o_pkt_done, o_pkt_abort}); end
    checks++; if (o_byte !== 8'h00 || o_err_cnt !== 8'h00) begin errors++; $display("[TB] FAIL rst_data got %h %0d exp 00 0", o_byte, o_err_cnt); end
    i_rst = 1'b0; i_rdy = 1'b1;
    repeat (6) tick();
    checks++; if (o_vld !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_post got vld %b busy %b exp 0 0", o_vld, o_busy); end
    checks++; if (done_cnt != d0 || abort_cnt != a0) begin errors++; $display("[TB] FAIL rst_pulses got done %0d abort %0d exp 0 0", done_cnt - d0, abort_cnt - a0); end
    i_timeout = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_sop = 1'b0; i_sym_vld = 1'b0; i_sym_err = 1'b0;
    i_rdy = 1'b1; i_pkt_len = '0; i_timeout = '0; i_sym = '0;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    i_rst = 1'b0; i_en = 1'b1;
    tick();
    $display("[TB] directed packet");
    test_directed();
    $display("[TB] random packets");
    test_random_packets();
    $display("[TB] timeout");
    test_timeout();
    $display("[TB] overflow");
    test_overflow();
    $display("[TB] error count and disable");
    test_err_cnt_and_disable();
    $display("[TB] reset mid capture");
    test_reset_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_pkt_ctrl.md
RX_PKT_CTRL -- requirements
Module: rx_pkt_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, byte-FIFO entries; SHALL be a power of two, 4..64.
REQ-002 Parameter LEN_W, default 8, width of the packet-length field in bytes.
REQ-003 Parameter TO_W, default 16, width of the symbol-timeout counter.
REQ-004 Port i_clk, input, 1, single clock for all logic.
REQ-005 Port i_rst, input, 1, synchronous active-high reset.
REQ-006 Port i_en, input, 1, capture enable; 0 forces IDLE.
REQ-007 Port i_pkt_len, input, LEN_W, payload bytes per packet; 0 is treated as 1; sampled on SOP acceptance.
REQ-008 Port i_timeout, input, TO_W, maximum cycles between symbols in CAPTURE; 0 disables the timeout.
REQ-009 Port i_sop, input, 1, single-cycle start-of-packet pulse from the correlator max_vld.
REQ-010 Port i_sym, input, 2, hard-decision symbol {I,Q} bits.
REQ-011 Port i_sym_vld, input, 1, i_sym is valid this cycle.
REQ-012 Port i_sym_err, input, 1, hard decision undecidable for this symbol.
REQ-013 Port o_byte, output, 8, payload byte.
REQ-014 Port o_last, output, 1, marks the final byte of a packet.
REQ-015 Port o_vld, output, 1, o_byte/o_last valid.
REQ-016 Port i_rdy, input, 1, downstream (DMA/AXI-Lite) accepts the byte.
REQ-017 Port o_busy, output, 1, high in CAPTURE or FLUSH.
REQ-018 Port o_pkt_done, output, 1, one-cycle pulse when the last byte is pushed.
REQ-019 Port o_pkt_abort, output, 1, one-cycle pulse on timeout abort.
REQ-020 Port o_ovf, output, 1, sticky: a byte was dropped on a full FIFO.
REQ-021 Port o_err_cnt, output, 8, saturating count of i_sym_err symbols since i_en rose.

Function
REQ-022 States SHALL be IDLE, SEARCH, CAPTURE, FLUSH; IDLE->SEARCH when i_en=1; any state->IDLE on the cycle after i_en=0.
REQ-023 SEARCH->CAPTURE on i_sop=1; a symbol valid in the SOP cycle SHALL NOT be captured.
REQ-024 i_sop in CAPTURE or FLUSH SHALL be ignored.
REQ-025 Packing SHALL be MSB-first, four symbols per byte: byte = {sym0,sym1,sym2,sym3}.
REQ-026 Errored symbols SHALL still be packed, and o_err_cnt SHALL increment, saturating at 255.
REQ-027 The completed byte SHALL be pushed one cycle after its 4th symbol; with an empty FIFO, o_vld SHALL assert 2 cycles after the 4th symbol.
REQ-028 The byte-count reaching the latched length SHALL push with last=1, pulse o_pkt_done, and go to FLUSH.
REQ-029 FLUSH->SEARCH when the FIFO is empty and not pushing.
REQ-030 In CAPTURE, an idle counter SHALL reset on every i_sym_vld.
REQ-031 When i_timeout≠0 and the idle count equals i_timeout, the block SHALL pulse o_pkt_abort, discard the partial byte, and go to SEARCH; pushed bytes still drain, and no o_last is emitted.
REQ-032 A push with the FIFO full SHALL drop the byte and set o_ovf; a pop and a push in the same cycle while full SHALL succeed.
REQ-033 Output SHALL use a valid/ready handshake: a transfer occurs on o_vld&i_rdy; o_byte/o_last SHALL be held stable while o_vld&!i_rdy.
REQ-034 i_en=0 SHALL flush the FIFO and the partial byte, and clear o_ovf and o_err_cnt.

Reset
REQ-035 On i_rst: state=IDLE, FIFO empty, and all outputs 0 (o_byte=0, o_err_cnt=0, o_ovf=0, pulses low).
REQ-036 Reset mid-packet SHALL discard all data with no o_pkt_done or o_pkt_abort.

Structure
REQ-037 Package rx_pkt_pkg SHALL hold the state encoding, SYMS_PER_BYTE=4, and the default widths.
REQ-038 The FIFO SHALL be sub-module rx_byte_fifo (9-bit wide, FIFO_DEPTH deep, first-word-fall-through, full/empty flags).

Verification
REQ-039 len=2, i_rdy=1, SOP, then symbols 3,2,1,0,0,1,2,3 -> bytes 0xE4, 0x1B (last=1); o_pkt_done pulse; state returns to SEARCH.
REQ-040 Timeout=10, SOP, 5 symbols then silence -> o_pkt_abort at idle count 10; exactly 1 byte output, o_last=0.
REQ-041 i_rdy=0, FIFO_DEPTH=16, len=20 -> 16 bytes held, o_ovf=1, 4 bytes dropped; o_byte stable throughout the stall.
REQ-042 Three symbols with i_sym_err=1 -> o_err_cnt=3; 300 errored symbols -> o_err_cnt=255.
REQ-043 Second i_sop mid-CAPTURE -> ignored, packet completes normally; i_en=0 mid-packet -> IDLE, FIFO empty, o_vld=0 next cycle.
REQ-044 i_rst asserted mid-CAPTURE -> all outputs 0 the next cycle, no done or abort pulse.
